// File: rtl/band_acc_pkg.sv
// Shared helpers for the band energy accumulator: bin reversal and band bounds.
// Band upper bounds are exclusive (first bin past the band).
package band_acc_pkg;

    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

    function automatic int band_lo(input int k, input int start, input int step);
        return start + k * step;
    endfunction

    function automatic int band_hi(input int k, input int start, input int step, input int len);
        return start + k * step + len;
    endfunction

    function automatic int span_hi(input int nb, input int start, input int step, input int len);
        return start + (nb - 1) * step + len;
    endfunction

endpackage

// File: rtl/band_acc_lane.sv
// One frame accumulator lane; exposes the value it will hold after this edge.
// With BAND_ACC_SAT_EN the lane saturates and keeps a sticky overflow flag.
module band_acc_lane
    import band_acc_pkg::*;
#(
    parameter int ACC_W = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_done,
    input  logic             i_add,
    input  logic [ACC_W-1:0] i_din,
`ifdef BAND_ACC_SAT_EN
    output logic             o_ovf_next,
`endif
    output logic [ACC_W-1:0] o_sum_next
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_sum;

`ifdef BAND_ACC_SAT_EN
    logic [ACC_W:0] w_wide;
    logic           r_ovf;

    assign w_wide     = {1'b0, r_acc} + {1'b0, i_din};
    assign w_sum      = w_wide[ACC_W] ? '1 : w_wide[ACC_W-1:0];
    assign o_ovf_next = r_ovf | (i_add & w_wide[ACC_W]);

    always_ff @(posedge clk) begin
        if (rst || i_clr || i_done) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= o_ovf_next;
        end
    end
`else
    assign w_sum = r_acc + i_din;
`endif

    assign o_sum_next = i_add ? w_sum : r_acc;

    // Frame end restarts from zero on the same edge the final sum is published.
    always_ff @(posedge clk) begin
        if (rst || i_clr || i_done) begin
            r_acc <= '0;
        end else begin
            r_acc <= o_sum_next;
        end
    end

endmodule

// File: rtl/band_energy_accumulator.sv
// Per-frame band energy accumulator over a (optionally bit-reversed) bin stream.
// Define BAND_ACC_SAT_EN for saturating lanes and the ovf output.
module band_energy_accumulator
    import band_acc_pkg::*;
#(
    parameter int DATA_W      = 31,
    parameter int ACC_W       = 31,
    parameter int FRAME_LEN   = 128,
    parameter int NUM_BANDS   = 11,
    parameter int BAND_START  = 0,
    parameter int BAND_STEP   = 1,
    parameter int BAND_LEN    = 3,
    parameter int BIT_REVERSE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          din,
    input  logic                       in_en,
    input  logic                       frame_rst,
    output logic [NUM_BANDS*ACC_W-1:0] band_out,
    output logic [ACC_W-1:0]           total_out,
`ifdef BAND_ACC_SAT_EN
    output logic [NUM_BANDS:0]         ovf,
`endif
    output logic                       out_valid
);

    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam int SPAN_HI = span_hi(NUM_BANDS, BAND_START, BAND_STEP, BAND_LEN);

    if (SPAN_HI > FRAME_LEN) begin : g_bad_span
        $error("band_energy_accumulator: highest bin %0d not below FRAME_LEN %0d",
               SPAN_HI - 1, FRAME_LEN);
    end

    logic [DATA_W-1:0]          r_din_q;
    logic                       r_in_en_q;
    logic [IDX_W-1:0]           r_idx;
    logic [IDX_W-1:0]           w_bin;
    logic [ACC_W-1:0]           w_din;
    logic                       w_done;
    logic [NUM_BANDS:0]         w_hit;
    logic [ACC_W-1:0]           w_sum_next [NUM_BANDS+1];
    logic [NUM_BANDS*ACC_W-1:0] r_band_out;
    logic [ACC_W-1:0]           r_total_out;
    logic                       r_out_valid;

    always_ff @(posedge clk) begin
        if (rst || frame_rst) begin
            r_din_q   <= '0;
            r_in_en_q <= 1'b0;
            r_idx     <= '0;
        end else begin
            r_din_q   <= din;
            r_in_en_q <= in_en;
            if (r_in_en_q) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    if (BIT_REVERSE != 0) begin : g_bitrev
        assign w_bin = IDX_W'(bitrev(32'(r_idx), IDX_W));
    end else begin : g_linear
        assign w_bin = r_idx;
    end

    assign w_din  = ACC_W'(r_din_q);
    // A coincident frame_rst wins over the frame end and suppresses the pulse.
    assign w_done = r_in_en_q && (r_idx == LAST_IDX) && !frame_rst;

`ifdef BAND_ACC_SAT_EN
    logic [NUM_BANDS:0] w_ovf_next;
    logic [NUM_BANDS:0] r_ovf;
`endif

    // Lanes 0..NUM_BANDS-1 are bands; lane NUM_BANDS is the total over the span.
    for (genvar gi = 0; gi <= NUM_BANDS; gi++) begin : g_lane
        localparam logic [31:0] LO = 32'((gi < NUM_BANDS) ?
            band_lo(gi, BAND_START, BAND_STEP) : BAND_START);
        localparam logic [31:0] HI = 32'((gi < NUM_BANDS) ?
            band_hi(gi, BAND_START, BAND_STEP, BAND_LEN) : SPAN_HI);

        assign w_hit[gi] = (32'(w_bin) >= LO) && (32'(w_bin) < HI);

        band_acc_lane #(
            .ACC_W (ACC_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_clr      (frame_rst),
            .i_done     (w_done),
            .i_add      (r_in_en_q && w_hit[gi]),
            .i_din      (w_din),
`ifdef BAND_ACC_SAT_EN
            .o_ovf_next (w_ovf_next[gi]),
`endif
            .o_sum_next (w_sum_next[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_band_out  <= '0;
            r_total_out <= '0;
            r_out_valid <= 1'b0;
`ifdef BAND_ACC_SAT_EN
            r_ovf       <= '0;
`endif
        end else begin
            r_out_valid <= w_done;
            if (w_done) begin
                for (int k = 0; k < NUM_BANDS; k++) begin
                    r_band_out[k*ACC_W +: ACC_W] <= w_sum_next[k];
                end
                r_total_out <= w_sum_next[NUM_BANDS];
`ifdef BAND_ACC_SAT_EN
                r_ovf       <= w_ovf_next;
`endif
            end
        end
    end

    assign band_out  = r_band_out;
    assign total_out = r_total_out;
    assign out_valid = r_out_valid;
`ifdef BAND_ACC_SAT_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_band_energy_accumulator.sv
// Randomised scoreboard bench: a per-bin reference model predicts each frame's
// sums; a monitor pops predictions whenever a DUT pulses out_valid.
module tb_band_energy_accumulator;

    localparam int NB  = 11;
    localparam int FL  = 128;
    localparam int BS  = 0;
    localparam int BST = 1;
    localparam int BL  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_rst = 1'b0;
    logic [30:0] din0 = '0;
    logic [7:0]  din1 = '0;
    logic in_en0 = 1'b0;
    logic in_en1 = 1'b0;
    logic [NB*31-1:0] band_out0;
    logic [NB*8-1:0]  band_out1;
    logic [30:0] total_out0;
    logic [7:0]  total_out1;
    logic out_valid0, out_valid1;
`ifdef BAND_ACC_SAT_EN
    logic [NB:0] ovf0, ovf1;
`endif

    always #5 clk = ~clk;

    band_energy_accumulator dut0 (
        .clk(clk), .rst(rst), .din(din0), .in_en(in_en0), .frame_rst(frame_rst),
        .band_out(band_out0), .total_out(total_out0),
`ifdef BAND_ACC_SAT_EN
        .ovf(ovf0),
`endif
        .out_valid(out_valid0)
    );

    band_energy_accumulator #(.DATA_W(8), .ACC_W(8)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .in_en(in_en1), .frame_rst(frame_rst),
        .band_out(band_out1), .total_out(total_out1),
`ifdef BAND_ACC_SAT_EN
        .ovf(ovf1),
`endif
        .out_valid(out_valid1)
    );

    typedef struct {
        longint      band [NB];
        longint      total;
        logic [NB:0] ovf;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t last0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    longint m_band [2][NB];
    longint m_total [2];
    int     m_idx [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int bin_of(input int i);
        int r = 0;
        for (int b = 0; b < 7; b++) if (((i >> b) & 1) != 0) r |= 1 << (6 - b);
        return r;
    endfunction

    function automatic longint fin(input longint s, input int w);
        longint mx = (longint'(1) << w) - 1;
`ifdef BAND_ACC_SAT_EN
        return (s > mx) ? mx : s;
`else
        return s & mx;
`endif
    endfunction

    task automatic model_clear(input int t);
        for (int k = 0; k < NB; k++) m_band[t][k] = 0;
        m_total[t] = 0;
        m_idx[t] = 0;
    endtask

    task automatic model_add(input int t, input longint d);
        int b = bin_of(m_idx[t]);
        int w = (t == 0) ? 31 : 8;
        longint mx = (longint'(1) << w) - 1;
        exp_t e;
        for (int k = 0; k < NB; k++) begin
            if (b >= BS + k * BST && b < BS + k * BST + BL) m_band[t][k] += d;
        end
        if (b >= BS && b < BS + (NB - 1) * BST + BL) m_total[t] += d;
        m_idx[t]++;
        if (m_idx[t] == FL) begin
            for (int k = 0; k < NB; k++) begin
                e.band[k] = fin(m_band[t][k], w);
                e.ovf[k]  = (m_band[t][k] > mx);
            end
            e.total   = fin(m_total[t], w);
            e.ovf[NB] = (m_total[t] > mx);
            e.cyc     = cyc + 2;
            if (t == 0) q0.push_back(e); else q1.push_back(e);
            model_clear(t);
        end
    endtask

    task automatic send(input int t, input longint d, input int gap);
        repeat (gap) begin
            @(posedge clk); #1;
            in_en0 = 1'b0; in_en1 = 1'b0;
        end
        @(posedge clk); #1;
        in_en0 = (t == 0); in_en1 = (t == 1);
        if (t == 0) din0 = d[30:0]; else din1 = d[7:0];
        model_add(t, d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_en0 = 1'b0; in_en1 = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid0) begin
            if (q0.size() == 0) begin
                chk("unexpected_pulse0", 1, 0);
            end else begin
                e = q0.pop_front();
                last0 = e;
                chk("latency0", cyc, e.cyc);
                for (int k = 0; k < NB; k++) chk($sformatf("band0[%0d]", k), band_out0[k*31 +: 31], e.band[k]);
                chk("total0", total_out0, e.total);
`ifdef BAND_ACC_SAT_EN
                chk("ovf0", ovf0, e.ovf);
`endif
            end
        end
        if (out_valid1) begin
            if (q1.size() == 0) begin
                chk("unexpected_pulse1", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("latency1", cyc, e.cyc);
                for (int k = 0; k < NB; k++) chk($sformatf("band1[%0d]", k), band_out1[k*8 +: 8], e.band[k]);
                chk("total1", total_out1, e.total);
`ifdef BAND_ACC_SAT_EN
                chk("ovf1", ovf1, e.ovf);
`endif
            end
        end
    end

    initial begin
        model_clear(0);
        model_clear(1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid0", out_valid0, 0);
        chk("rst_band0", band_out0, 0);
        chk("rst_total0", total_out0, 0);
        chk("rst_valid1", out_valid1, 0);
        chk("rst_total1", total_out1, 0);
        rst = 1'b0;

        // 1: din=1 contiguous
        for (int i = 0; i < FL; i++) send(0, 1, 0);
        idle(4);
        // 2: din = bin number
        for (int i = 0; i < FL; i++) send(0, bin_of(i), 0);
        idle(4);
        // 3: same with random gaps
        for (int i = 0; i < FL; i++) send(0, bin_of(i), $urandom_range(0, 5));
        idle(4);
        // 4: back-to-back frames
        for (int i = 0; i < FL; i++) send(0, 1, 0);
        for (int i = 0; i < FL; i++) send(0, 2, 0);
        idle(4);

        // 5a: frame_rst mid-frame, din presented with it is discarded
        for (int i = 0; i < 60; i++) send(0, 1, 0);
        @(posedge clk); #1;
        in_en0 = 1'b1; din0 = 31'($urandom); frame_rst = 1'b1;
        model_clear(0);
        @(posedge clk); #1;
        in_en0 = 1'b0; frame_rst = 1'b0;
        chk("hold_after_frst", total_out0, last0.total);
        chk("novalid_after_frst", out_valid0, 0);
        for (int i = 0; i < FL; i++) send(0, 1, 0);
        idle(4);

        // 5b: rst mid-frame
        for (int i = 0; i < 60; i++) send(0, 1, 0);
        @(posedge clk); #1;
        in_en0 = 1'b0; rst = 1'b1;
        model_clear(0);
        model_clear(1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_band0", band_out0, 0);
        chk("rst_mid_total0", total_out0, 0);
        chk("rst_mid_valid0", out_valid0, 0);
        for (int i = 0; i < FL; i++) send(0, 1, 0);
        idle(4);

        // 6: narrow instance, din=100 overflows every lane
        for (int i = 0; i < FL; i++) send(1, 100, 0);
        idle(4);

        // 7: random data with random gaps on both instances
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < FL; i++) send(0, longint'($urandom) & 64'h7FFF_FFFF, $urandom_range(0, 2));
        for (int i = 0; i < FL; i++) send(1, longint'($urandom_range(0, 255)), $urandom_range(0, 2));

        for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
        chk("pending0", q0.size(), 0);
        chk("pending1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
